// File: rtl/seq_divider_6b.sv
// 6-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Results and the divide-by-zero flag are registered and held until the next completion.
module seq_divider_6b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] dividend,
    input  logic [5:0] divisor,
    output logic [5:0] quotient,
    output logic [5:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] count_reg, count_next;
    logic [5:0] dvd_reg, dvd_next;
    logic [5:0] dvs_reg, dvs_next;
    logic [5:0] rem_reg, rem_next;
    logic [5:0] quotient_reg, quotient_next;
    logic [5:0] remainder_reg, remainder_next;
    logic       dbz_reg, dbz_next;

    logic [6:0] partial;
    logic [6:0] diff;
    logic       ge;
    logic [5:0] rem_step;
    logic [5:0] quo_step;

    // The dividend register doubles as the quotient accumulator: each step shifts
    // out one dividend bit at the top and shifts in one quotient bit at the bottom.
    assign partial  = {rem_reg, dvd_reg[5]};
    assign diff     = partial - {1'b0, dvs_reg};
    // rem_reg < divisor keeps partial < 2*divisor, so diff[6] is exactly the borrow.
    assign ge       = ~diff[6];
    assign rem_step = ge ? diff[5:0] : partial[5:0];
    assign quo_step = {dvd_reg[4:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= 3'd0;
            dvd_reg       <= 6'd0;
            dvs_reg       <= 6'd0;
            rem_reg       <= 6'd0;
            quotient_reg  <= 6'd0;
            remainder_reg <= 6'd0;
            dbz_reg       <= 1'b0;
        end else begin
            count_reg     <= count_next;
            dvd_reg       <= dvd_next;
            dvs_reg       <= dvs_next;
            rem_reg       <= rem_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        dvd_next       = dvd_reg;
        dvs_next       = dvs_reg;
        rem_next       = rem_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        case (state_reg)
            CALC: begin
                rem_next   = rem_step;
                dvd_next   = quo_step;
                count_next = count_reg + 3'd1;
                if (count_reg == 3'd5) begin
                    state_next     = DONE;
                    quotient_next  = quo_step;
                    remainder_next = rem_step;
                    dbz_next       = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE lasts one cycle.
                state_next = IDLE;
                if (start) begin
                    if (divisor == 6'd0) begin
                        state_next     = DONE;
                        quotient_next  = 6'h3F;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                    end else begin
                        state_next = CALC;
                        dvd_next   = dividend;
                        dvs_next   = divisor;
                        rem_next   = 6'd0;
                        count_next = 3'd0;
                    end
                end
            end
        endcase
    end

    assign busy        = (state_reg == CALC);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule
